// File: rtl/xbar_out_port.sv
// xbar_out_port: per-output wormhole lock with a single registered output stage
module xbar_out_port #(
  parameter int IN_N = 5,
  parameter int FLIT_W = 10,
  localparam int SW = $clog2(IN_N)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [IN_N-1:0]        req_i,
  input  logic [IN_N*FLIT_W-1:0] data_i,
  input  logic [SW-1:0]          grant_i,
  output logic [IN_N-1:0]        arb_req_o,
  output logic [IN_N-1:0]        ready_o,
  output logic [FLIT_W-1:0]      data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   locked_o,
  output logic [SW-1:0]          sel_o,
  output logic                   err_o
);
  localparam int NP = 1 << SW;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [SW-1:0] sel, idx;
  logic [FLIT_W-1:0] flit_p [NP];
  logic [FLIT_W-1:0] cur;
  logic [NP-1:0] req_p, ready_p;
  logic [1:0] typ;
  logic slot_free, hit, pop, err_set;
  // Pad to a power of two so out-of-range grants simply see no request
  for (genvar k = 0; k < NP; k++) begin : g_in
    if (k < IN_N) begin : g_real
      assign flit_p[k] = data_i[k*FLIT_W +: FLIT_W];
      assign arb_req_o[k] = state == IDLE && req_i[k] && data_i[k*FLIT_W+FLIT_W-2];
    end else begin : g_pad
      assign flit_p[k] = '0;
    end
  end
  assign req_p = NP'(req_i);
  assign ready_o = ready_p[IN_N-1:0];
  assign locked_o = state == LOCKED;
  assign sel_o = sel;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      sel <= '0;
      data_o <= '0;
      valid_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == LOCKED) sel <= grant_i;
      if (pop) data_o <= cur;
      valid_o <= pop || (valid_o && !ready_i);
      err_o <= err_o || err_set;
    end
  always_comb begin
    state_n = state == IDLE ? (pop && typ == 2'b01 ? LOCKED : IDLE)
                            : (pop && typ != 2'b00 ? IDLE : LOCKED);
  end
  // A head seen while locked is still forwarded but aborts the lock
  always_comb begin
    slot_free = !valid_o || ready_i;
    idx = state == LOCKED ? sel : grant_i;
    cur = flit_p[idx];
    typ = cur[FLIT_W-1 -: 2];
    hit = req_p[idx];
    pop = hit && slot_free && (state == LOCKED || typ[0]);
    err_set = state == LOCKED ? pop && typ[0] : hit && !typ[0];
    ready_p = pop ? NP'(1) << idx : '0;
  end
endmodule

// File: tb/tb_xbar_out_port.sv
// tb_xbar_out_port: table-driven directed vectors plus reset/abort sequences
module tb_xbar_out_port;
  logic clk = 1'b0, rst_n = 1'b0, ready_i = 1'b0;
  logic [4:0] req = '0, arb_req, ready_o;
  logic [49:0] data = '0;
  logic [2:0] grant = '0, sel_o;
  logic [9:0] data_o;
  logic valid_o, locked_o, err_o;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  xbar_out_port dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .data_i(data), .grant_i(grant),
    .arb_req_o(arb_req), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .locked_o(locked_o), .sel_o(sel_o), .err_o(err_o)
  );

  typedef struct {
    logic [4:0] req;
    logic [49:0] data;
    logic [2:0] grant;
    logic rdy;
    logic [4:0] e_ready, e_arb;
    logic [9:0] e_data;
    logic e_valid, e_locked;
    logic [2:0] e_sel;
    logic e_err;
  } vec_t;
  vec_t vec [22];

  function automatic logic [9:0] f(logic [1:0] t, logic [7:0] p);
    return {t, p};
  endfunction
  function automatic logic [49:0] pk(logic [9:0] d4, d3, d2, d1, d0);
    return {d4, d3, d2, d1, d0};
  endfunction
  function automatic vec_t mk(logic [4:0] r, logic [49:0] d, logic [2:0] g, logic rd,
                              logic [4:0] er, ea, logic [9:0] ed, logic ev, el,
                              logic [2:0] es, logic ee);
    vec_t v;
    v.req = r; v.data = d; v.grant = g; v.rdy = rd; v.e_ready = er; v.e_arb = ea;
    v.e_data = ed; v.e_valid = ev; v.e_locked = el; v.e_sel = es; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s got %0h expected %0h", n, a, e);
    else passed++;
  endtask

  task automatic drive(logic [4:0] r, logic [49:0] d, logic [2:0] g, logic rd);
    @(negedge clk);
    req = r; data = d; grant = g; ready_i = rd;
    #4;
  endtask

  initial begin
    vec[0]  = mk(5'b00100, pk(0, 0, f(3, 8'h2A), 0, 0), 2, 1, 5'b00100, 5'b00100, 10'h32A, 1, 0, 0, 0);
    vec[1]  = mk(5'b00000, '0, 0, 1, 0, 0, 10'h32A, 0, 0, 0, 0);
    vec[2]  = mk(5'b01010, pk(0, f(1, 8'h33), 0, f(1, 8'h11), 0), 0, 1, 0, 5'b01010, 10'h32A, 0, 0, 0, 0);
    vec[3]  = mk(5'b01010, pk(0, f(1, 8'h33), 0, f(1, 8'h11), 0), 1, 1, 5'b00010, 5'b01010, 10'h111, 1, 1, 1, 0);
    vec[4]  = mk(5'b01010, pk(0, f(1, 8'h33), 0, f(0, 8'h12), 0), 2, 1, 5'b00010, 0, 10'h012, 1, 1, 1, 0);
    vec[5]  = mk(5'b01010, pk(0, f(1, 8'h33), 0, f(0, 8'h13), 0), 3, 1, 5'b00010, 0, 10'h013, 1, 1, 1, 0);
    vec[6]  = mk(5'b01010, pk(0, f(1, 8'h33), 0, f(2, 8'h14), 0), 4, 1, 5'b00010, 0, 10'h214, 1, 0, 1, 0);
    vec[7]  = mk(5'b01000, pk(0, f(1, 8'h33), 0, 0, 0), 0, 1, 0, 5'b01000, 10'h214, 0, 0, 1, 0);
    vec[8]  = mk(5'b01000, pk(0, f(1, 8'h33), 0, 0, 0), 3, 1, 5'b01000, 5'b01000, 10'h133, 1, 1, 3, 0);
    vec[9]  = mk(5'b01000, pk(0, f(0, 8'h34), 0, 0, 0), 0, 1, 5'b01000, 0, 10'h034, 1, 1, 3, 0);
    vec[10] = mk(5'b01000, pk(0, f(0, 8'h35), 0, 0, 0), 0, 0, 0, 0, 10'h034, 1, 1, 3, 0);
    vec[11] = mk(5'b01000, pk(0, f(0, 8'h35), 0, 0, 0), 0, 0, 0, 0, 10'h034, 1, 1, 3, 0);
    vec[12] = mk(5'b01000, pk(0, f(0, 8'h35), 0, 0, 0), 0, 0, 0, 0, 10'h034, 1, 1, 3, 0);
    vec[13] = mk(5'b01000, pk(0, f(0, 8'h35), 0, 0, 0), 0, 1, 5'b01000, 0, 10'h035, 1, 1, 3, 0);
    vec[14] = mk(5'b01000, pk(0, f(2, 8'h36), 0, 0, 0), 0, 1, 5'b01000, 0, 10'h236, 1, 0, 3, 0);
    vec[15] = mk(5'b00000, '0, 0, 0, 0, 0, 10'h236, 1, 0, 3, 0);
    vec[16] = mk(5'b00000, '0, 0, 1, 0, 0, 10'h236, 0, 0, 3, 0);
    vec[17] = mk(5'b10000, pk(f(3, 8'hC4), 0, 0, 0, 0), 0, 1, 0, 5'b10000, 10'h236, 0, 0, 3, 0);
    vec[18] = mk(5'b10000, pk(f(3, 8'hC4), 0, 0, 0, 0), 4, 1, 5'b10000, 5'b10000, 10'h3C4, 1, 0, 3, 0);
    vec[19] = mk(5'b00001, pk(0, 0, 0, 0, f(1, 8'h01)), 5, 1, 0, 5'b00001, 10'h3C4, 0, 0, 3, 0);
    vec[20] = mk(5'b00010, pk(0, 0, 0, f(0, 8'h55), 0), 1, 1, 0, 0, 10'h3C4, 0, 0, 3, 1);
    vec[21] = mk(5'b00000, '0, 0, 1, 0, 0, 10'h3C4, 0, 0, 3, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_o", valid_o, 0);
    chk("reset data_o", data_o, 0);
    chk("reset locked_o", locked_o, 0);
    chk("reset sel_o", sel_o, 0);
    chk("reset err_o", err_o, 0);
    chk("reset ready_o", ready_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(vec[i].req, vec[i].data, vec[i].grant, vec[i].rdy);
      chk($sformatf("v%0d ready_o", i), ready_o, vec[i].e_ready);
      chk($sformatf("v%0d arb_req_o", i), arb_req, vec[i].e_arb);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d data_o", i), data_o, vec[i].e_data);
      chk($sformatf("v%0d valid_o", i), valid_o, vec[i].e_valid);
      chk($sformatf("v%0d locked_o", i), locked_o, vec[i].e_locked);
      chk($sformatf("v%0d sel_o", i), sel_o, vec[i].e_sel);
      chk($sformatf("v%0d err_o", i), err_o, vec[i].e_err);
    end

    drive('0, '0, 0, 1);
    rst_n = 1'b0;
    #1;
    chk("err cleared by reset", err_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(5'b00100, pk(0, 0, f(1, 8'h02), 0, 0), 2, 1);
    @(posedge clk);
    #1;
    chk("abort lock", locked_o, 1);
    chk("abort sel", sel_o, 2);
    drive(5'b00100, pk(0, 0, f(1, 8'hAA), 0, 0), 2, 1);
    chk("abort ready_o", ready_o, 5'b00100);
    @(posedge clk);
    #1;
    chk("abort data_o", data_o, 10'h1AA);
    chk("abort locked_o", locked_o, 0);
    chk("abort err_o", err_o, 1);

    drive('0, '0, 0, 1);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'b00001, pk(0, 0, 0, 0, f(1, 8'h01)), 0, 1);
    @(posedge clk);
    #1;
    chk("mid lock", locked_o, 1);
    drive(5'b00001, pk(0, 0, 0, 0, f(0, 8'hEE)), 3, 1);
    @(posedge clk);
    #1;
    chk("mid data_o", data_o, 10'h0EE);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst valid_o", valid_o, 0);
    chk("mid rst locked_o", locked_o, 0);
    chk("mid rst data_o", data_o, 0);
    chk("mid rst err_o", err_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'b10000, pk(f(3, 8'hC4), 0, 0, 0, 0), 4, 1);
    chk("fresh ready_o", ready_o, 5'b10000);
    @(posedge clk);
    #1;
    chk("fresh data_o", data_o, 10'h3C4);
    chk("fresh valid_o", valid_o, 1);
    chk("fresh locked_o", locked_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
